// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared constants and types for the D flip-flop leaf cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

   // Default register width: a single bit, so the cell drops in as d/clk/rst/q.
   localparam int DFF_DEFAULT_WIDTH = 1;

   // Reset polarity, kept as a named type so the reset test reads as intent.
   typedef enum logic {
      RST_ACTIVE_LOW  = 1'b0,
      RST_ACTIVE_HIGH = 1'b1
   } rst_polarity_e;

endpackage : dff_pkg
`default_nettype wire

// File: rtl/dff_bit.sv
`default_nettype none
// ============================================================================
//  Module      : dff_bit
//  Description : One-bit rising-edge register with asynchronous active-low
//                reset and a per-bit reset value.
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_bit
   import dff_pkg::*;
#(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic r_q;

   // Capture d on every rising edge; reset takes effect without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ACTIVE_LOW) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule : dff_bit
`default_nettype wire

// File: rtl/d_flip_flop.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop
//  Description : Parameterisable-width D-type register. Each bit is an
//                independent dff_bit, so bit i of q depends only on bit i of d.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_flip_flop
   import dff_pkg::*;
#(
   parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // One register cell per bit; each cell receives its own reset-value bit.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         dff_bit #(
            .RESET_VALUE (RESET_VALUE[gi])
         ) u_dff_bit (
            .clk (clk),
            .rst (rst),
            .d   (d[gi]),
            .q   (q[gi])
         );
      end
   endgenerate

endmodule : d_flip_flop
`default_nettype wire

// File: tb/tb_d_flip_flop.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_d_flip_flop
//  Description : Self-checking bench for d_flip_flop, 1-bit and 8-bit variants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_flip_flop;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       d    = 1'b0;
   logic       q;
   logic       rst8 = 1'b1;
   logic [7:0] d8   = 8'h00;
   logic [7:0] q8;

   int n_checks = 0;
   int n_errors = 0;

   // Expected values: each d applied is queued and must appear on q after the next edge.
   logic       exp_q1 [$];
   logic [7:0] exp_q8 [$];

   d_flip_flop u_dut1 (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q)
   );

   d_flip_flop #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5)
   ) u_dut8 (
      .clk (clk),
      .rst (rst8),
      .d   (d8),
      .q   (q8)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ... ns.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_until(input time t);
      if (t > $time) #(t - $time);
   endtask

   initial begin
      // Reset at start, d = 1 throughout.
      rst  = 1'b0;
      d    = 1'b1;
      rst8 = 1'b0;
      d8   = 8'h3C;
      wait_until(6);
      check("rst_edge_ignored", {7'b0, q}, 8'h00);
      check("rst8_value", q8, 8'hA5);
      wait_until(10);
      rst = 1'b1;
      #0;
      check("rst_release_hold", {7'b0, q}, 8'h00);
      wait_until(16);
      check("first_capture", {7'b0, q}, 8'h01);

      // Capture and hold, including falling edges.
      wait_until(18); d = 1'b1;
      wait_until(21); check("hold_fall20", {7'b0, q}, 8'h01);
      wait_until(26); check("cap_25", {7'b0, q}, 8'h01);
      wait_until(31); check("hold_fall30", {7'b0, q}, 8'h01);
      wait_until(36); check("cap_35", {7'b0, q}, 8'h01);
      wait_until(38); d = 1'b0;

      // Glitch on d between edges must not reach q.
      wait_until(41); d = 1'b1;
      wait_until(42); check("glitch_hold", {7'b0, q}, 8'h01);
      wait_until(43); d = 1'b0;
      wait_until(44); check("glitch_hold2", {7'b0, q}, 8'h01);
      wait_until(46); check("cap_45", {7'b0, q}, 8'h00);

      // Mid-cycle asynchronous reset.
      wait_until(48); d = 1'b1;
      wait_until(56); check("cap_55", {7'b0, q}, 8'h01);
      wait_until(60); check("rst8_hold", q8, 8'hA5);
      wait_until(62); rst = 1'b0;
      wait_until(63); check("async_rst", {7'b0, q}, 8'h00);
      wait_until(68); rst = 1'b1;
      wait_until(69); check("post_release_hold", {7'b0, q}, 8'h00);
      wait_until(76); check("post_release_cap", {7'b0, q}, 8'h01);

      // Wide variant release and capture.
      wait_until(80); rst8 = 1'b1;
      wait_until(81); check("rst8_release_hold", q8, 8'hA5);
      wait_until(86); check("wide_cap", q8, 8'h3C);

      // Random stream: d applied 3 ns after each rising edge.
      for (int i = 0; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (exp_q1.size() > 0) begin
            check("rand_q1", {7'b0, q}, {7'b0, exp_q1.pop_front()});
            check("rand_q8", q8, exp_q8.pop_front());
         end
         #2;
         if (i < 20) begin
            d  = 1'($urandom_range(0, 1));
            d8 = 8'($urandom);
            exp_q1.push_back(d);
            exp_q8.push_back(d8);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_d_flip_flop
`default_nettype wire
